// File: rtl/wash_phase_timer.sv
// wash_phase_timer
// Times each washing-machine phase commanded by the controller and returns
// a one-cycle *_done pulse when the phase duration has elapsed.
// Optional build macro: WASH_PHASE_TIMER_FAST_SIM_EN bypasses the prescaler
// so every unpaused RUN cycle counts as one time unit.
module wash_phase_timer #(
    parameter int TICK_DIV = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fill_water,
    input  logic             wash,
    input  logic             rinse,
    input  logic             spin,
    input  logic             drain,
    input  logic             dry,
    input  logic             pause,
    input  logic [1:0]       temp_select,
    input  logic [1:0]       cloth_type,
    input  logic [1:0]       cycle_duration,
    output logic             fill_done,
    output logic             wash_done,
    output logic             rinse_done,
    output logic             spin_done,
    output logic             drain_done,
    output logic             dry_done,
    output logic             busy,
    output logic             phase_err,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Phase identities double as bit positions in the command/done vectors.
    localparam logic [2:0] PH_FILL  = 3'd0;
    localparam logic [2:0] PH_WASH  = 3'd1;
    localparam logic [2:0] PH_RINSE = 3'd2;
    localparam logic [2:0] PH_SPIN  = 3'd3;
    localparam logic [2:0] PH_DRAIN = 3'd4;
    localparam logic [2:0] PH_DRY   = 3'd5;

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int unsigned     CNT_MAX  = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << CNT_W) - 32'd1);

    state_t           state_q;
    logic [2:0]       phase_q;
    logic [PRE_W-1:0] presc_q;
    logic [CNT_W-1:0] remaining_q;
    logic [5:0]       done_q;

    logic [5:0]       cmd;
    logic             cmd_multi;
    logic             cmd_single;
    logic [2:0]       cmd_idx_d;
    logic [CNT_W-1:0] load_units_d;
    logic             latched_ok;
    logic             load_en;
    logic             tick;

    // Duration in time units for a phase, from the selections at load time.
    // Spin/dry halving happens after scaling; the fill heating bonus is unscaled.
    function automatic logic [CNT_W-1:0] phase_units(
        input logic [2:0] ph,
        input logic [1:0] temp,
        input logic [1:0] cloth,
        input logic [1:0] dur
    );
        int unsigned base;
        int unsigned mult;
        int unsigned units;
        case (ph)
            PH_FILL:  base = 4;
            PH_WASH:  base = 10;
            PH_RINSE: base = 6;
            PH_SPIN:  base = 4;
            PH_DRAIN: base = 3;
            PH_DRY:   base = 8;
            default:  base = 0;
        endcase
        case (dur)
            2'b01:   mult = 3;
            2'b10:   mult = 4;
            default: mult = 2;
        endcase
        units = base * mult;
        if (ph == PH_FILL && temp == 2'b10) begin
            units = units + 2;
        end
        if ((ph == PH_SPIN || ph == PH_DRY) && cloth != 2'b00) begin
            units = units >> 1;
        end
        if (units > CNT_MAX) begin
            units = CNT_MAX;
        end
        return CNT_W'(units);
    endfunction

    assign cmd        = {dry, drain, spin, rinse, wash, fill_water};
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign cmd_multi  = |(cmd & (cmd - 6'd1));
    assign cmd_single = (cmd != 6'd0) && !cmd_multi;

    // Encode the (single) active command into its phase identity.
    always_comb begin
        cmd_idx_d = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (cmd[i]) begin
                cmd_idx_d = 3'(i);
            end
        end
    end

    assign load_units_d = phase_units(cmd_idx_d, temp_select, cloth_type, cycle_duration);

    // The latched phase counts as "still commanded" only if it is the sole
    // command; a second command high is treated as the latched one dropping.
    assign latched_ok = cmd_single && (cmd_idx_d == phase_q);
    assign load_en    = cmd_single && ((state_q == S_IDLE) || !latched_ok);

`ifdef WASH_PHASE_TIMER_FAST_SIM_EN
    assign tick = 1'b1;
`else
    assign tick = (presc_q == PRE_LAST);
`endif

    // Phase FSM: load, prescaled countdown, done pulse, abort and restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 3'd0;
            presc_q     <= '0;
            remaining_q <= '0;
            done_q      <= '0;
        end else begin
            done_q <= '0;
            if (load_en) begin
                state_q     <= S_RUN;
                phase_q     <= cmd_idx_d;
                presc_q     <= '0;
                remaining_q <= load_units_d;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (!latched_ok) begin
                            // Abort: remaining is left frozen for observation.
                            state_q <= S_IDLE;
                        end else if (!pause) begin
                            if (tick) begin
                                presc_q <= '0;
                                if (remaining_q <= CNT_ONE) begin
                                    remaining_q      <= '0;
                                    done_q[phase_q]  <= 1'b1;
                                    state_q          <= S_HOLD;
                                end else begin
                                    remaining_q <= remaining_q - CNT_ONE;
                                end
                            end else begin
                                presc_q <= presc_q + PRE_ONE;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!latched_ok) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign fill_done  = done_q[PH_FILL];
    assign wash_done  = done_q[PH_WASH];
    assign rinse_done = done_q[PH_RINSE];
    assign spin_done  = done_q[PH_SPIN];
    assign drain_done = done_q[PH_DRAIN];
    assign dry_done   = done_q[PH_DRY];
    assign busy       = (state_q == S_RUN);
    assign phase_err  = cmd_multi;
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: directed scenarios plus
// randomized phases checked against a duration/timing reference model.
module tb_wash_phase_timer;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;
`ifdef WASH_PHASE_TIMER_FAST_SIM_EN
    localparam int TD = 1;
`else
    localparam int TD = TICK_DIV;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             fill_water, wash, rinse, spin, drain, dry, pause;
    logic [1:0]       temp_select, cloth_type, cycle_duration;
    logic             fill_done, wash_done, rinse_done, spin_done, drain_done, dry_done;
    logic             busy, phase_err;
    logic [CNT_W-1:0] remaining;
    logic [5:0]       dv;

    int tests_run = 0;
    int tests_failed = 0;
    int base_tab [6] = '{4, 10, 6, 4, 3, 8};
    int mult_tab [4] = '{2, 3, 4, 2};

    assign dv = {dry_done, drain_done, spin_done, rinse_done, wash_done, fill_done};

    always #5 clk = ~clk;

    wash_phase_timer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .fill_water(fill_water), .wash(wash), .rinse(rinse),
        .spin(spin), .drain(drain), .dry(dry), .pause(pause),
        .temp_select(temp_select), .cloth_type(cloth_type),
        .cycle_duration(cycle_duration),
        .fill_done(fill_done), .wash_done(wash_done), .rinse_done(rinse_done),
        .spin_done(spin_done), .drain_done(drain_done), .dry_done(dry_done),
        .busy(busy), .phase_err(phase_err), .remaining(remaining)
    );

    // Reference: phase duration in time units from the programme rules.
    function automatic int model_units(input int ph, input logic [1:0] t,
                                       input logic [1:0] c, input logic [1:0] d);
        int u;
        u = base_tab[ph] * mult_tab[d];
        if (ph == 0 && t == 2'b10) u = u + 2;
        if ((ph == 3 || ph == 5) && c != 2'b00) u = u / 2;
        if (u > 255) u = 255;
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [5:0] v);
        fill_water = v[0]; wash = v[1]; rinse = v[2];
        spin = v[3]; drain = v[4]; dry = v[5];
    endtask

    // Load a phase, count down (with an optional pause window), verify the
    // single done pulse lands at the model's edge, and stay in HOLD.
    task automatic run_phase(input int ph, input logic [1:0] t, input logic [1:0] c,
                             input logic [1:0] d, input int pstart, input int plen,
                             input string tag);
        int exp_d, exp_n, rise_at, pulses, wrong, rem_at_last;
        logic [5:0] exp_vec;
        exp_d = model_units(ph, t, c, d);
        exp_n = exp_d * TD + plen;
        exp_vec = 6'd1 << ph;
        temp_select = t; cloth_type = c; cycle_duration = d;
        pause = 1'b0;
        set_cmd(exp_vec);
        step();
        tests_run++;
        if (busy !== 1'b1 || remaining !== CNT_W'(exp_d)) begin
            tests_failed++;
            $display("FAIL %s_load: busy=%b remaining=%0d, required busy=1 remaining=%0d",
                     tag, busy, remaining, exp_d);
        end
        rise_at = -1; pulses = 0; wrong = 0; rem_at_last = -1;
        for (int i = 1; i <= exp_n + 3; i++) begin
            pause = (i > pstart && i <= pstart + plen);
            temp_select = 2'($urandom); cloth_type = 2'($urandom);
            cycle_duration = 2'($urandom);
            step();
            if (i == exp_n - 1) rem_at_last = int'(remaining);
            if (dv != 6'd0) begin
                pulses++;
                if (rise_at < 0) rise_at = i;
                if (dv !== exp_vec) wrong++;
            end
        end
        pause = 1'b0;
        tests_run++;
        if (rise_at != exp_n || pulses != 1 || wrong != 0) begin
            tests_failed++;
            $display("FAIL %s_done: rose at %0d pulses=%0d wrongbit=%0d, required at %0d pulses=1 wrongbit=0",
                     tag, rise_at, pulses, wrong, exp_n);
        end
        tests_run++;
        if (rem_at_last != 1 || busy !== 1'b0 || remaining !== '0) begin
            tests_failed++;
            $display("FAIL %s_hold: rem_before=%0d busy=%b remaining=%0d, required 1/0/0",
                     tag, rem_at_last, busy, remaining);
        end
        $display("[TB] %s phase=%0d D=%0d pause=%0d done_after=%0d", tag, ph, exp_d, plen, rise_at);
    endtask

    task automatic drop_to_idle(input string tag);
        set_cmd(6'd0);
        step();
        tests_run++;
        if (busy !== 1'b0 || dv !== 6'd0 || phase_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: busy=%b done=%b err=%b, required 0/0/0", tag, busy, dv, phase_err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pause = 1'b0;
        temp_select = 2'b00; cloth_type = 2'b00; cycle_duration = 2'b00;
        set_cmd(6'd0);
        step(); step();
        tests_run++;
        if (busy !== 1'b0 || remaining !== '0 || dv !== 6'd0 || phase_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b remaining=%0d done=%b err=%b, required all 0",
                     busy, remaining, dv, phase_err);
        end
        reset_n = 1'b1;
        step();
        tests_run++;
        if (busy !== 1'b0 || remaining !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: busy=%b remaining=%0d, required 0/0", busy, remaining);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_plan_cases();
        run_phase(1, 2'b00, 2'b00, 2'b01, 0, 0, "wash_01");
        drop_to_idle("wash_01");
        run_phase(0, 2'b10, 2'b00, 2'b01, 0, 0, "fill_hot");
        drop_to_idle("fill_hot");
        run_phase(0, 2'b00, 2'b00, 2'b01, 0, 0, "fill_cold");
        drop_to_idle("fill_cold");
        run_phase(3, 2'b00, 2'b01, 2'b10, 0, 0, "spin_nc");
        drop_to_idle("spin_nc");
        run_phase(3, 2'b00, 2'b01, 2'b10, 3, 10, "spin_pause");
        drop_to_idle("spin_pause");
    endtask

    task automatic test_abort();
        int exp_d, exp_rem, bad;
        exp_d = model_units(2, 2'b00, 2'b00, 2'b10);
        temp_select = 2'b00; cloth_type = 2'b00; cycle_duration = 2'b10;
        set_cmd(6'b000100);
        step();
        for (int i = 0; i < 20; i++) step();
        set_cmd(6'd0);
        step();
        exp_rem = exp_d - 20 / TD;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy !== 1'b0 || dv !== 6'd0 || remaining !== CNT_W'(exp_rem)) bad++;
        end
        tests_run++;
        if (busy !== 1'b0 || remaining !== CNT_W'(exp_rem) || bad != 0) begin
            tests_failed++;
            $display("FAIL abort: busy=%b remaining=%0d badcycles=%0d, required busy=0 remaining=%0d badcycles=0",
                     busy, remaining, bad, exp_rem);
        end
        $display("[TB] abort rinse remaining frozen at %0d", remaining);
        run_phase(2, 2'b00, 2'b00, 2'b10, 0, 0, "rinse_reload");
        drop_to_idle("rinse_reload");
    endtask

    task automatic test_conflict();
        int bad;
        temp_select = 2'b01; cloth_type = 2'b00; cycle_duration = 2'b00;
        set_cmd(6'b000011);
        #1;
        tests_run++;
        if (phase_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL conflict_err: phase_err=%b, required 1", phase_err);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy !== 1'b0 || dv !== 6'd0 || phase_err !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL conflict_idle: bad cycles=%0d, required 0", bad);
        end
        set_cmd(6'b000010);
        step();
        tests_run++;
        if (busy !== 1'b1 || phase_err !== 1'b0 ||
            remaining !== CNT_W'(model_units(1, 2'b01, 2'b00, 2'b00))) begin
            tests_failed++;
            $display("FAIL conflict_release: busy=%b err=%b remaining=%0d, required 1/0/%0d",
                     busy, phase_err, remaining, model_units(1, 2'b01, 2'b00, 2'b00));
        end
        drop_to_idle("conflict");
        // Second command appearing mid-run aborts without a pulse.
        set_cmd(6'b010000);
        step(); step(); step();
        set_cmd(6'b011000);
        step();
        tests_run++;
        if (busy !== 1'b0 || phase_err !== 1'b1 || dv !== 6'd0) begin
            tests_failed++;
            $display("FAIL run_conflict: busy=%b err=%b done=%b, required 0/1/0", busy, phase_err, dv);
        end
        $display("[TB] conflict handling checked");
        run_phase(3, 2'b00, 2'b00, 2'b00, 0, 0, "spin_after_err");
        drop_to_idle("spin_after_err");
    endtask

    task automatic test_back_to_back();
        // Restart from RUN: wash partially timed, then drain replaces it.
        temp_select = 2'b00; cloth_type = 2'b00; cycle_duration = 2'b01;
        set_cmd(6'b000010);
        step();
        for (int i = 0; i < 7; i++) step();
        run_phase(4, 2'b00, 2'b00, 2'b01, 0, 0, "restart_drain");
        // Straight from HOLD into a new phase.
        run_phase(5, 2'b01, 2'b11, 2'b10, 2, 5, "hold_to_dry");
        drop_to_idle("hold_to_dry");
    endtask

    task automatic test_reset_mid();
        temp_select = 2'b00; cloth_type = 2'b00; cycle_duration = 2'b10;
        set_cmd(6'b100000);
        step();
        for (int i = 0; i < 10; i++) step();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || remaining !== '0 || dv !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_async: busy=%b remaining=%0d done=%b, required 0/0/0",
                     busy, remaining, dv);
        end
        step(); step();
        reset_n = 1'b1;
        run_phase(5, 2'b00, 2'b00, 2'b10, 0, 0, "dry_after_reset");
        drop_to_idle("dry_after_reset");
    endtask

    task automatic test_random();
        int ph, last_ph, d_units, pstart, plen;
        logic [1:0] t, c, d;
        last_ph = -1;
        for (int n = 0; n < 16; n++) begin
            ph = $urandom_range(0, 5);
            t = 2'($urandom); c = 2'($urandom); d = 2'($urandom);
            d_units = model_units(ph, t, c, d);
            plen = $urandom_range(0, 8);
            pstart = $urandom_range(0, d_units * TD - 1);
            if (ph == last_ph || $urandom_range(0, 1) == 1) drop_to_idle("rand_gap");
            run_phase(ph, t, c, d, pstart, plen, "rand");
            last_ph = ph;
        end
        drop_to_idle("rand_end");
    endtask

    initial begin
        test_reset();
        test_plan_cases();
        test_abort();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
